// File: rtl/param_wb_cache.sv
// Purpose : parametrised write-back / write-allocate N-way set-associative cache, tree PLRU.
// Latency : hit answers in the request cycle; a miss costs writeback wait + fill wait + 1 cycle.
// Backpr. : CPU request is held until mem_resp; pmem_read/pmem_write are held until pmem_resp.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_read/mem_write       CPU request strobes (both high = write)
//   mem_byte_enable          write byte mask, bit0 = low byte
//   mem_address/mem_wdata    CPU byte address (bit0 ignored) and write word
//   mem_resp/mem_rdata       one-cycle completion pulse and read word
//   pmem_*                   line-wide physical memory port (fill / writeback)
// Optional: define CACHE_PERF_CNT_EN to add perf_clr and hit_cnt/miss_cnt/wb_cnt counters.

module param_wb_cache #(
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [1:0]              mem_byte_enable,
  input  logic [15:0]             mem_address,
  input  logic [15:0]             mem_wdata,
  output logic                    mem_resp,
  output logic [15:0]             mem_rdata,
  output logic [15:0]             pmem_address,
  input  logic [8*LINE_BYTES-1:0] pmem_rdata,
  output logic [8*LINE_BYTES-1:0] pmem_wdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  input  logic                    pmem_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  input  logic                    perf_clr,
  output logic [15:0]             hit_cnt,
  output logic [15:0]             miss_cnt,
  output logic [15:0]             wb_cnt
`endif
);

  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 16 - OFF_W - IDX_W;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int WSEL_W = OFF_W - 1;
  localparam int PL_W   = NUM_WAYS - 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

  // Tree PLRU: node n has children 2n+1 (left) and 2n+2 (right).
  // A node bit of 1 means the right subtree holds the least recently used way.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] bits);
    logic [WAY_W-1:0] way;
    logic             b;
    int               node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b    = bits[node];
      way  = WAY_W'({way, b});
      node = 2 * node + 1 + int'(b);
    end
    return way;
  endfunction

  // Point every node on the path to 'way' at the opposite subtree.
  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [PL_W-1:0] res;
    logic            b;
    int              node;
    res  = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b         = way[WAY_W-1-l];
      res[node] = ~b;
      node      = 2 * node + 1 + int'(b);
    end
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [LINE_W-1:0] data_q  [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0] data_d  [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0]  tag_q   [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0]  tag_d   [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
  logic [PL_W-1:0]   plru_q  [NUM_SETS];
  logic [PL_W-1:0]   plru_d  [NUM_SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              req;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  victim_sel;
  logic [LINE_W-1:0] merged_line;
  logic              unused_addr_b0;

  assign idx            = mem_address[OFF_W +: IDX_W];
  assign tag            = mem_address[15 -: TAG_W];
  assign wsel           = mem_address[OFF_W-1:1];
  assign req            = mem_read | mem_write;
  assign unused_addr_b0 = mem_address[0];

  // Tag compare across all ways and victim choice: lowest invalid way first,
  // otherwise whatever the set's PLRU tree points at.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_sel = inv_found ? inv_way : plru_victim(plru_q[idx]);
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    data_d       = data_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    plru_d       = plru_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = data_q[victim_q][idx];
    merged_line  = data_q[hit_way][idx];

    unique case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          mem_resp    = 1'b1;
          mem_rdata   = merged_line[wsel*16 +: 16];
          plru_d[idx] = plru_touch(plru_q[idx], hit_way);
          if (mem_write) begin
            if (mem_byte_enable[0]) merged_line[wsel*16 +: 8]     = mem_wdata[7:0];
            if (mem_byte_enable[1]) merged_line[wsel*16 + 8 +: 8] = mem_wdata[15:8];
            data_d[hit_way][idx]  = merged_line;
            dirty_d[idx][hit_way] = 1'b1;
          end
        end else if (req) begin
          victim_d = victim_sel;
          state_d  = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][idx], idx, {OFF_W{1'b0}}};
        if (pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, idx, {OFF_W{1'b0}}};
        if (pmem_resp) begin
          data_d[victim_q][idx]  = pmem_rdata;
          tag_d[victim_q][idx]   = tag;
          valid_d[idx][victim_q] = 1'b1;
          dirty_d[idx][victim_q] = 1'b0;
          state_d                = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      plru_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      plru_q  <= plru_d;
    end
  end

  // Payload storage is never cleared; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    victim_q <= victim_d;
    data_q   <= data_d;
    tag_q    <= tag_d;
  end

`ifdef CACHE_PERF_CNT_EN
  logic        miss_pend_q, miss_pend_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [15:0] wb_cnt_q, wb_cnt_d;
  logic        miss_evt, wb_evt, hit_evt;

  // miss_pend marks a request that already missed, so its eventual
  // post-fill response is not counted as a hit.
  always_comb begin
    miss_evt    = (state_q == S_IDLE) && req && !hit;
    wb_evt      = (state_q == S_WB) && pmem_resp;
    hit_evt     = mem_resp && !miss_pend_q;
    miss_pend_d = miss_pend_q;
    if (miss_evt)      miss_pend_d = 1'b1;
    else if (mem_resp) miss_pend_d = 1'b0;
    hit_cnt_d  = perf_clr ? 16'd0 : hit_cnt_q  + 16'(hit_evt);
    miss_cnt_d = perf_clr ? 16'd0 : miss_cnt_q + 16'(miss_evt);
    wb_cnt_d   = perf_clr ? 16'd0 : wb_cnt_q   + 16'(wb_evt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_pend_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
    end else begin
      miss_pend_q <= miss_pend_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_param_wb_cache.sv
`timescale 1ns/1ps
module tb_param_wb_cache;

  typedef struct {
    logic [15:0] rdata;
    bit          hit;
    int          issue;
  } rexp_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    bit          chk_w3;
    logic [15:0] w3;
  } pexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         mem_read   [2];
  logic         mem_write  [2];
  logic [1:0]   mem_be     [2];
  logic [15:0]  mem_addr   [2];
  logic [15:0]  mem_wdata  [2];
  logic         mem_resp   [2];
  logic [15:0]  mem_rdata  [2];
  logic [15:0]  pmem_addr  [2];
  logic [127:0] pmem_rdata [2];
  logic [127:0] pmem_wdata [2];
  logic         pmem_read  [2];
  logic         pmem_write [2];
  logic         pmem_resp  [2];
`ifdef CACHE_PERF_CNT_EN
  logic         perf_clr;
  logic [15:0]  hit_cnt  [2];
  logic [15:0]  miss_cnt [2];
  logic [15:0]  wb_cnt   [2];
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    last_pr [2];
  bit    hold    [2];
  rexp_t rq [2][$];
  pexp_t pq [2][$];
  logic [127:0] mem_line [logic [15:0]];

  param_wb_cache u0 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_byte_enable(mem_be[0]),
    .mem_address(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_resp(mem_resp[0]), .mem_rdata(mem_rdata[0]),
    .pmem_address(pmem_addr[0]), .pmem_rdata(pmem_rdata[0]), .pmem_wdata(pmem_wdata[0]),
    .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]), .pmem_resp(pmem_resp[0])
`ifdef CACHE_PERF_CNT_EN
    , .perf_clr(perf_clr), .hit_cnt(hit_cnt[0]), .miss_cnt(miss_cnt[0]), .wb_cnt(wb_cnt[0])
`endif
  );

  param_wb_cache #(.NUM_WAYS(4), .NUM_SETS(4), .LINE_BYTES(16)) u1 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_byte_enable(mem_be[1]),
    .mem_address(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_resp(mem_resp[1]), .mem_rdata(mem_rdata[1]),
    .pmem_address(pmem_addr[1]), .pmem_rdata(pmem_rdata[1]), .pmem_wdata(pmem_wdata[1]),
    .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]), .pmem_resp(pmem_resp[1])
`ifdef CACHE_PERF_CNT_EN
    , .perf_clr(perf_clr), .hit_cnt(hit_cnt[1]), .miss_cnt(miss_cnt[1]), .wb_cnt(wb_cnt[1])
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Default line contents: word k of the line at address a is a+k.
  function automatic logic [127:0] pat(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = a + 16'(k);
    return l;
  endfunction

  // Response scoreboard: data and timing of every mem_resp.
  always @(negedge clk) begin
    rexp_t e;
    for (int u = 0; u < 2; u++) begin
      if (!rst && mem_resp[u]) begin
        if (rq[u].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_resp inst=%0d actual=1 required=0", u);
        end else begin
          e = rq[u].pop_front();
          chk($sformatf("rdata_u%0d", u), mem_rdata[u], e.rdata);
          chk($sformatf("resp_cycle_u%0d", u), 16'(cyc),
              e.hit ? 16'(e.issue) : 16'(last_pr[u] + 1));
        end
      end
    end
  end

  // Physical memory: checks each new request against the expected queue,
  // answers two cycles later with a one-cycle pmem_resp.
  task automatic responder(input int u);
    pexp_t       e;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (!rst && !hold[u] && (pmem_read[u] || pmem_write[u])) begin
        a = pmem_addr[u];
        if (pq[u].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pmem inst=%0d addr=%h rd=%b wr=%b required=none",
                   u, a, pmem_read[u], pmem_write[u]);
        end else begin
          e = pq[u].pop_front();
          chk($sformatf("pmem_is_write_u%0d", u), 16'(pmem_write[u]), 16'(e.wr));
          chk($sformatf("pmem_addr_u%0d", u), a, e.addr);
          if (e.chk_w3) chk($sformatf("pmem_wdata_w3_u%0d", u), pmem_wdata[u][63:48], e.w3);
        end
        if (pmem_write[u]) mem_line[a] = pmem_wdata[u];
        repeat (2) @(posedge clk);
        #1;
        pmem_rdata[u] = mem_line.exists(a) ? mem_line[a] : pat(a);
        pmem_resp[u]  = 1'b1;
        last_pr[u]    = cyc;
        @(posedge clk);
        #1 pmem_resp[u] = 1'b0;
      end
    end
  endtask

  initial responder(0);
  initial responder(1);

  task automatic expect_pm(input int u, input bit wr, input logic [15:0] a,
                           input bit c3, input logic [15:0] w3);
    pexp_t e;
    e.wr = wr; e.addr = a; e.chk_w3 = c3; e.w3 = w3;
    pq[u].push_back(e);
  endtask

  task automatic wait_resp(input int u);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_resp[u] && n < 300);
    if (!mem_resp[u]) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout inst=%0d addr=%h actual=none required=mem_resp", u, mem_addr[u]);
    end
    @(posedge clk);
    #1;
    mem_read[u]  = 1'b0;
    mem_write[u] = 1'b0;
  endtask

  task automatic access(input int u, input bit wr, input logic [15:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input logic [15:0] exp, input bit hit);
    rexp_t e;
    @(posedge clk);
    #1;
    mem_read[u]  = !wr;
    mem_write[u] = wr;
    mem_addr[u]  = a;
    mem_be[u]    = be;
    mem_wdata[u] = wd;
    e.rdata = exp; e.hit = hit; e.issue = cyc;
    rq[u].push_back(e);
    wait_resp(u);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] l;
    rexp_t        e;
    int           n;
    rst = 1'b1;
`ifdef CACHE_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    for (int u = 0; u < 2; u++) begin
      mem_read[u] = 0; mem_write[u] = 0; mem_be[u] = 2'b11; mem_addr[u] = '0;
      mem_wdata[u] = '0; pmem_rdata[u] = '0; pmem_resp[u] = 0; hold[u] = 0; last_pr[u] = 0;
    end
    l = pat(16'h1230);
    l[63:48] = 16'hBEEF;
    mem_line[16'h1230] = l;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_resp",   16'(mem_resp[0]),   16'h0);
    chk("rst_mem_rdata",  mem_rdata[0],       16'h0);
    chk("rst_pmem_read",  16'(pmem_read[0]),  16'h0);
    chk("rst_pmem_write", 16'(pmem_write[1]), 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold read, then hit; byte write and read-back.
    expect_pm(0, 0, 16'h1230, 0, 16'h0);
    access(0, 0, 16'h1236, 2'b11, 16'h0,    16'hBEEF, 0);
    access(0, 0, 16'h1236, 2'b11, 16'h0,    16'hBEEF, 1);
    access(0, 1, 16'h1236, 2'b01, 16'hAA55, 16'hBEEF, 1);
    access(0, 0, 16'h1236, 2'b11, 16'h0,    16'hBE55, 1);

    // Set 3 thrash: clean fill, then dirty eviction of 0x1230.
    expect_pm(0, 0, 16'h2230, 0, 16'h0);
    access(0, 0, 16'h2230, 2'b11, 16'h0, 16'h2230, 0);
    expect_pm(0, 1, 16'h1230, 1, 16'hBE55);
    expect_pm(0, 0, 16'h3230, 0, 16'h0);
    access(0, 0, 16'h323A, 2'b11, 16'h0, 16'h3235, 0);
    access(0, 0, 16'h2234, 2'b11, 16'h0, 16'h2232, 1);

`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    chk("hit_cnt",  hit_cnt[0],  16'd4);
    chk("miss_cnt", miss_cnt[0], 16'd3);
    chk("wb_cnt",   wb_cnt[0],   16'd1);
    @(posedge clk); #1 perf_clr = 1'b1;
    @(posedge clk); #1 perf_clr = 1'b0;
    @(negedge clk);
    chk("hit_cnt_clr",  hit_cnt[0],  16'd0);
    chk("miss_cnt_clr", miss_cnt[0], 16'd0);
    chk("wb_cnt_clr",   wb_cnt[0],   16'd0);
`endif

    // The written-back line comes back with the merged byte.
    expect_pm(0, 0, 16'h1230, 0, 16'h0);
    access(0, 0, 16'h1236, 2'b11, 16'h0, 16'hBE55, 0);

    // 4-way PLRU: fill ways 0..3 of set 0, touch 0,2,1 -> way 3 is victim.
    for (int t = 0; t < 4; t++) begin
      expect_pm(1, 0, 16'(t << 8), 0, 16'h0);
      access(1, 0, 16'((t << 8) | 2), 2'b11, 16'h0, 16'((t << 8) + 1), 0);
    end
    access(1, 0, 16'h0002, 2'b11, 16'h0, 16'h0001, 1);
    access(1, 0, 16'h0202, 2'b11, 16'h0, 16'h0201, 1);
    access(1, 0, 16'h0102, 2'b11, 16'h0, 16'h0101, 1);
    // A stray pmem_resp while idle must change nothing.
    @(posedge clk); #1 pmem_resp[1] = 1'b1;
    @(posedge clk); #1 pmem_resp[1] = 1'b0;
    expect_pm(1, 0, 16'h0400, 0, 16'h0);
    access(1, 0, 16'h0406, 2'b11, 16'h0, 16'h0403, 0);
    access(1, 0, 16'h0002, 2'b11, 16'h0, 16'h0001, 1);
    access(1, 0, 16'h0102, 2'b11, 16'h0, 16'h0101, 1);
    access(1, 0, 16'h0202, 2'b11, 16'h0, 16'h0201, 1);
    expect_pm(1, 0, 16'h0500, 0, 16'h0);
    access(1, 0, 16'h0500, 2'b11, 16'h0, 16'h0500, 0);
    access(1, 0, 16'h0102, 2'b11, 16'h0, 16'h0101, 1);
    access(1, 0, 16'h0202, 2'b11, 16'h0, 16'h0201, 1);
    access(1, 0, 16'h0406, 2'b11, 16'h0, 16'h0403, 1);
    expect_pm(1, 0, 16'h0000, 0, 16'h0);
    access(1, 0, 16'h0000, 2'b11, 16'h0, 16'h0000, 0);

    // Reset during FILL: strobe drops, the request then refetches.
    hold[0] = 1'b1;
    @(posedge clk);
    #1;
    mem_read[0] = 1'b1;
    mem_addr[0] = 16'h4236;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_read[0] && n < 20);
    chk("fill_req_before_rst",  16'(pmem_read[0]), 16'h1);
    chk("fill_addr_before_rst", pmem_addr[0],      16'h4230);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("pmem_read_after_rst", 16'(pmem_read[0]), 16'h0);
    hold[0] = 1'b0;
    expect_pm(0, 0, 16'h4230, 0, 16'h0);
    e.rdata = 16'h4233; e.hit = 0; e.issue = cyc;
    rq[0].push_back(e);
    wait_resp(0);

    repeat (5) @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("resp_queue_empty_u%0d", u), 16'(rq[u].size()), 16'h0);
      chk($sformatf("pmem_queue_empty_u%0d", u), 16'(pq[u].size()), 16'h0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
